// File: rtl/axi_sram_slave.sv
// AXI4 responder over an internal word-addressed RAM; one outstanding burst per direction, INCR 32-bit beats.
// Optional start-address window check (DECERR outside the window) is enabled by defining AXI_SLV_ADDR_CHECK_EN.
module axi_sram_slave #(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    logic ar_bad, aw_bad;
`ifdef AXI_SLV_ADDR_CHECK_EN
    // 33-bit compare so a window touching the top of the address map cannot overflow
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << MEM_AW);
    assign ar_bad = ({1'b0, araddr} < WIN_LO) || ({1'b0, araddr} >= WIN_HI);
    assign aw_bad = ({1'b0, awaddr} < WIN_LO) || ({1'b0, awaddr} >= WIN_HI);
`else
    assign ar_bad = 1'b0;
    assign aw_bad = 1'b0;
`endif
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr, awaddr, BASE_ADDR};

    // ---------------- read engine ----------------
    r_state_t          r_state, r_next;
    logic [MEM_AW-1:0] r_idx, r_addr;
    logic [7:0]        r_len, r_beat;
    logic              r_bad, ar_hs, r_hs, r_adv;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;
    assign rlast = rvalid & (r_beat == r_len);
    assign r_adv = r_hs & ~rlast;

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid)       r_next = R_DATA;
            R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state == R_IDLE);
        rvalid  = (r_state == R_DATA);
    end

    // Next word is fetched on the accepting edge so beats stream without bubbles
    assign r_addr = ar_hs ? araddr[MEM_AW+1:2] : r_idx + 1'b1;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rid    <= '0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
            r_len  <= '0;
            r_beat <= '0;
            r_idx  <= '0;
            r_bad  <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid    <= arid;
                r_len  <= arlen;
                r_beat <= '0;
                r_bad  <= ar_bad;
                rresp  <= ar_bad ? RESP_DECERR : RESP_OKAY;
            end else if (r_adv) begin
                r_beat <= r_beat + 1'b1;
            end
            if (ar_hs || r_adv) begin
                r_idx <= r_addr;
                rdata <= (ar_hs ? ar_bad : r_bad) ? 32'd0 : mem[r_addr];
            end
        end
    end

    // ---------------- write engine ----------------
    w_state_t          w_state, w_next;
    logic [MEM_AW-1:0] w_idx;
    logic [7:0]        w_len, w_beat;
    logic              w_bad, w_err, aw_hs, w_hs, w_end;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign w_end = w_hs & (w_beat == w_len);

    always_ff @(posedge aclk) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (awvalid) w_next = W_DATA;
            W_DATA:  if (w_end)   w_next = W_RESP;
            W_RESP:  if (bready)  w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (w_state == W_IDLE);
        wready  = (w_state == W_DATA);
        bvalid  = (w_state == W_RESP);
        bresp   = RESP_OKAY;
        if (w_state == W_RESP)
            bresp = w_bad ? RESP_DECERR : (w_err ? RESP_SLVERR : RESP_OKAY);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bid    <= '0;
            w_idx  <= '0;
            w_len  <= '0;
            w_beat <= '0;
            w_bad  <= 1'b0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            bid    <= awid;
            w_idx  <= awaddr[MEM_AW+1:2];
            w_len  <= awlen;
            w_beat <= '0;
            w_bad  <= aw_bad;
            w_err  <= 1'b0;
        end else if (w_hs) begin
            w_idx  <= w_idx + 1'b1;
            w_beat <= w_beat + 1'b1;
            // burst length is set by awlen; a misplaced wlast only flags the response
            if (wlast != (w_beat == w_len)) w_err <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && w_hs && !w_bad) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single/burst transfers, read stall, byte strobes, wlast error,
// index wrap, mid-burst reset and (when AXI_SLV_ADDR_CHECK_EN is defined) window decode.
module tb_axi_sram_slave;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    always #5 aclk = ~aclk;

    axi_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wbuf [8];
    logic [31:0] rbuf [8];
    logic        rl   [8];
    logic [1:0]  rr   [8];
    logic [1:0]  bres;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_wr(input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] strb, input int last_at);
        int n;
        awid = 4'hA; awaddr = addr; awlen = len; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin step(); n++; end
        chk("awready", awready, 1);
        step();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbuf[b]; wstrb = strb; wlast = (b == last_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin step(); n++; end
            chk("wready", wready, 1);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin step(); n++; end
        chk("bvalid", bvalid, 1);
        chk("bid", bid, 4'hA);
        bres = bresp;
        step();
        bready = 1'b0;
        chk("b_done", {awready, bvalid}, 2'b10);
    endtask

    task automatic axi_rd(input logic [31:0] addr, input logic [7:0] len, input int stall_at);
        int n;
        logic [31:0] d;
        logic l;
        arid = 4'h5; araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin step(); n++; end
        chk("arready", arready, 1);
        step();
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            chk("rvalid", rvalid, 1);
            chk("rid", rid, 4'h5);
            if (b == stall_at) begin
                rready = 1'b0; d = rdata; l = rlast;
                repeat (3) begin
                    step();
                    chk("hold_rdata", rdata, d);
                    chk("hold_rlast", rlast, l);
                    chk("hold_rvalid", rvalid, 1);
                end
                rready = 1'b1;
            end
            rbuf[b] = rdata; rl[b] = rlast; rr[b] = rresp;
            step();
        end
        rready = 1'b0;
        chk("r_done", {arready, rvalid}, 2'b10);
    endtask

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) step();
        chk("rst_ctl", {arready, awready, rvalid, rlast, wready, bvalid}, 6'b110000);
        chk("rst_ids", {rid, bid, rresp, bresp}, 12'h000);
        chk("rst_rdata", rdata, 0);
        aresetn = 1'b1;
        step();

        // single beat
        wbuf[0] = 32'h12345678;
        axi_wr(32'h1c000010, 0, 4'hF, 0);
        chk("t1_bresp", bres, 2'b00);
        axi_rd(32'h1c000010, 0, -1);
        chk("t1_rdata", rbuf[0], 32'h12345678);
        chk("t1_rlast", rl[0], 1);
        chk("t1_rresp", rr[0], 2'b00);

        // 4-beat burst, streaming and stalled reads
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        axi_wr(32'h1c000100, 3, 4'hF, 3);
        chk("t2_bresp", bres, 2'b00);
        axi_rd(32'h1c000100, 3, -1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_rdata", rbuf[i], 32'hA0 + i);
            chk("t2_rlast", rl[i], (i == 3));
        end
        axi_rd(32'h1c000100, 3, 2);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rdata", rbuf[i], 32'hA0 + i);
            chk("t3_rlast", rl[i], (i == 3));
        end

        // byte strobes, then an all-zero strobe
        wbuf[0] = 32'h11111111;
        axi_wr(32'h1c000200, 0, 4'hF, 0);
        wbuf[0] = 32'hAABBCCDD;
        axi_wr(32'h1c000200, 0, 4'b0101, 0);
        axi_rd(32'h1c000200, 0, -1);
        chk("t4_strb", rbuf[0], 32'h11BB11DD);
        wbuf[0] = 32'hDEADBEEF;
        axi_wr(32'h1c000200, 0, 4'h0, 0);
        chk("t4_bresp0", bres, 2'b00);
        axi_rd(32'h1c000200, 0, -1);
        chk("t4_nostrb", rbuf[0], 32'h11BB11DD);

        // early wlast on beat 1 of len3: data still lands, SLVERR
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + i;
        axi_wr(32'h1c000300, 3, 4'hF, 1);
        chk("t5_bresp", bres, 2'b10);
        axi_rd(32'h1c000300, 3, -1);
        for (int i = 0; i < 4; i++) chk("t5_rdata", rbuf[i], 32'hC0 + i);

        // wrap from index 0xFFF to 0
        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1;
        axi_wr(32'h1c003ffc, 1, 4'hF, 1);
        chk("t6_bresp", bres, 2'b00);
        axi_rd(32'h1c003ffc, 1, -1);
        chk("t6_rd0", rbuf[0], 32'hB0);
        chk("t6_rd1", rbuf[1], 32'hB1);
        chk("t6_rlast", {rl[0], rl[1]}, 2'b01);
        axi_rd(32'h1c000000, 0, -1);
        chk("t6_word0", rbuf[0], 32'hB1);

        // address outside the window
        wbuf[0] = 32'h5A5A5A5A;
        axi_wr(32'h00000000, 0, 4'hF, 0);
`ifdef AXI_SLV_ADDR_CHECK_EN
        chk("t7_bresp", bres, 2'b11);
        axi_rd(32'h00000000, 2, -1);
        for (int i = 0; i < 3; i++) begin
            chk("t7_rresp", rr[i], 2'b11);
            chk("t7_rdata", rbuf[i], 0);
            chk("t7_rlast", rl[i], (i == 2));
        end
        axi_rd(32'h1c000000, 0, -1);
        chk("t7_word0", rbuf[0], 32'hB1);
`else
        chk("t7_bresp", bres, 2'b00);
        axi_rd(32'h00000000, 0, -1);
        chk("t7_rresp", rr[0], 2'b00);
        chk("t7_alias", rbuf[0], 32'h5A5A5A5A);
        axi_rd(32'h1c000000, 0, -1);
        chk("t7_word0", rbuf[0], 32'h5A5A5A5A);
`endif

        // reset in the middle of a write burst after two beats
        awid = 4'h3; awaddr = 32'h1c000400; awlen = 8'd3; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        wdata = 32'hE0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        step();
        wdata = 32'hE1;
        step();
        wvalid = 1'b0;
        aresetn = 1'b0;
        step();
        chk("t8_rst", {awready, wready, bvalid, arready, rvalid}, 5'b10010);
        aresetn = 1'b1;
        step();
        step();
        chk("t8_nob", {awready, bvalid}, 2'b10);
        axi_rd(32'h1c000400, 1, -1);
        chk("t8_rd0", rbuf[0], 32'hE0);
        chk("t8_rd1", rbuf[1], 32'hE1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
